wb_stage: RTL

Write-back stage for the 10-instruction single-issue MIPS core: a MEM/WB pipeline register with hold and flush, instruction decode for the destination register, write-back data selection, and the single write port driving the general register file. It sits between the data-memory stage and the register file and is the only source of register-file writes. It also exposes the in-flight write for operand bypass and keeps a retired-instruction counter.

---
 rtl/wb_stage.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// ============================================================================
// Module   : wb_stage
// Purpose  : Write-back stage of the single-issue MIPS core. It holds the
//            MEM/WB pipeline register (with hold and flush), decodes the
//            destination register, selects the write-back data, and drives
//            the only write port of the general register file. It also
//            exposes the in-flight write for operand bypass, keeps a count
//            of retired entries, and flags undecodable instructions.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            in_valid/in_ready   - upstream handshake (in_ready = !wb_hold)
//            in_pc/instr/alu/dm  - instruction payload from the memory stage
//            wb_hold, flush      - stall / discard controls
//            grf_*               - register-file write port and write trace
//            fwd_*               - bypass view of the pending write
//            illegal, retired    - retire-side status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_dm,
  input  logic        wb_hold,
  input  logic        flush,
  output logic        grf_we,
  output logic [4:0]  grf_waddr,
  output logic [31:0] grf_wdata,
  output logic [31:0] grf_wpc,
  output logic        fwd_valid,
  output logic [4:0]  fwd_addr,
  output logic [31:0] fwd_data,
  output logic        illegal,
  output logic [31:0] retired
);

  localparam logic [4:0] c_RA = 5'd31;

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_alu;
  logic [31:0] r_dm;
  logic [31:0] r_retired;
  logic        r_illegal;

  logic        w_writes;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        w_undecodable;
  logic        w_vw;
  logic        w_retire;

  // An entry retires on the first edge where it is neither stalled nor
  // discarded.
  assign w_retire = r_valid && !wb_hold && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_instr   <= '0;
      r_alu     <= '0;
      r_dm      <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      if (w_retire) begin
        r_retired <= r_retired + 32'd1;
        r_illegal <= w_undecodable;
      end
      if (flush) begin
        // Data registers are left as-is; only the valid bit matters.
        r_valid <= 1'b0;
      end else if (!wb_hold) begin
        r_valid <= in_valid;
        if (in_valid) begin
          r_pc    <= in_pc;
          r_instr <= in_instr;
          r_alu   <= in_alu;
          r_dm    <= in_dm;
        end
      end
    end
  end

  // Destination / data decode from the registered instruction word.
  always_comb begin
    w_writes      = 1'b0;
    w_addr        = 5'd0;
    w_data        = 32'd0;
    w_undecodable = 1'b0;
    case (r_instr[31:26])
      6'b000000: begin
        if (r_instr != 32'd0) begin
          case (r_instr[5:0])
            6'b100001, 6'b100011: begin
              w_writes = 1'b1;
              w_addr   = r_instr[15:11];
              w_data   = r_alu;
            end
            6'b001000: ;
            default:   w_undecodable = 1'b1;
          endcase
        end
      end
      6'b001101, 6'b001111: begin
        w_writes = 1'b1;
        w_addr   = r_instr[20:16];
        w_data   = r_alu;
      end
      6'b100011: begin
        w_writes = 1'b1;
        w_addr   = r_instr[20:16];
        w_data   = r_dm;
      end
      6'b101011, 6'b000100: ;
      6'b000011: begin
        w_writes = 1'b1;
        w_addr   = c_RA;
        w_data   = r_pc + 32'd4;
      end
      default: w_undecodable = 1'b1;
    endcase
  end

  assign w_vw      = r_valid && w_writes;
  assign grf_waddr = w_vw ? w_addr : 5'd0;
  assign grf_wdata = w_vw ? w_data : 32'd0;
  assign grf_wpc   = w_vw ? r_pc   : 32'd0;

  // Bypass ignores wb_hold so stalled consumers still see the pending value;
  // writes to $0 are never issued nor forwarded.
  assign fwd_valid = w_vw && (w_addr != 5'd0);
  assign fwd_addr  = grf_waddr;
  assign fwd_data  = grf_wdata;
  assign grf_we    = fwd_valid && !wb_hold;

  assign in_ready  = !wb_hold;
  assign illegal   = r_illegal;
  assign retired   = r_retired;

endmodule

`default_nettype wire
